// File: rtl/oven_pkg.sv
// Shared oven command definitions: controller states, temperature/time codes
// and the time-code-to-seconds mapping used by the menu controller and the timer.
package oven_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREHEAT,
    COOK,
    PAUSE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    TEMP_OFF,
    TEMP_LOW,
    TEMP_MED,
    TEMP_HIGH
  } temp_code_t;

  typedef enum logic [1:0] {
    TIME_NONE,
    TIME_1,
    TIME_2,
    TIME_3
  } time_code_t;

  localparam int DEF_TIME1 = 30;
  localparam int DEF_TIME2 = 60;
  localparam int DEF_TIME3 = 120;

  function automatic int cook_secs(input logic [1:0] code, input int t1, input int t2,
                                   input int t3);
    case (code)
      TIME_1:  return t1;
      TIME_2:  return t2;
      TIME_3:  return t3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/oven_sec_tick.sv
// One-second prescaler: counts enabled clocks 0..TICKS_PER_SEC-1 and flags the last count.
module oven_sec_tick
  #(parameter int TICKS_PER_SEC = 100)
  (input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick);

  localparam int CNT_W = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  // Reflects the count even while frozen; the owner only acts on it when enabled.
  assign tick = (count == LAST);

endmodule

// File: rtl/oven_cook_timer.sv
// Cook execution controller: preheat, timed cook, door pause, cancel and
// completion buzzer, driven by the committed command from the menu controller.
module oven_cook_timer
  import oven_pkg::*;
  #(parameter int TICKS_PER_SEC     = 100,
    parameter int SEC_W             = 8,
    parameter int PREHEAT_PER_LEVEL = 10,
    parameter int TIME1             = DEF_TIME1,
    parameter int TIME2             = DEF_TIME2,
    parameter int TIME3             = DEF_TIME3,
    parameter int BUZZ_SECS         = 3)
  (input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       temp,
   input  logic [1:0]       temp_time,
   input  logic             door_open,
   input  logic             cancel,
   output logic [1:0]       heater,
   output logic             busy,
   output logic [SEC_W-1:0] remaining,
   output logic             done,
   output logic             buzzer,
   output logic             reject);

  localparam int BUZZ_W = (BUZZ_SECS < 2) ? 1 : $clog2(BUZZ_SECS + 1);
  localparam logic [SEC_W-1:0] ONE_SEC = SEC_W'(1);

  if (3 * PREHEAT_PER_LEVEL >= 2 ** SEC_W || TIME3 >= 2 ** SEC_W) begin : g_width_check
    $fatal(1, "oven_cook_timer: preheat or cook constant does not fit SEC_W");
  end

  state_t            state_q, state_d, ret_q, ret_d;
  logic [1:0]        temp_q, temp_d, time_q, time_d;
  logic [BUZZ_W-1:0] buzz_q, buzz_d;
  logic [SEC_W-1:0]  remaining_d;
  logic [1:0]        heater_d;
  logic              busy_d, done_d, buzzer_d, reject_d;
  logic              start_q, start_edge;
  logic              tick, tick_en, tick_clr;

  assign start_edge = start & ~start_q;

  oven_sec_tick #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_sec_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      temp_q    <= '0;
      time_q    <= '0;
      buzz_q    <= '0;
      start_q   <= 1'b0;
      heater    <= '0;
      busy      <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
      buzzer    <= 1'b0;
      reject    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      temp_q    <= temp_d;
      time_q    <= time_d;
      buzz_q    <= buzz_d;
      start_q   <= start;
      heater    <= heater_d;
      busy      <= busy_d;
      remaining <= remaining_d;
      done      <= done_d;
      buzzer    <= buzzer_d;
      reject    <= reject_d;
    end
  end

  // Priority inside an active run: cancel, then door, then the second tick.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    temp_d      = temp_q;
    time_d      = time_q;
    buzz_d      = buzz_q;
    heater_d    = heater;
    busy_d      = busy;
    remaining_d = remaining;
    buzzer_d    = buzzer;
    done_d      = 1'b0;
    reject_d    = 1'b0;
    tick_en     = 1'b0;
    tick_clr    = 1'b0;

    if (state_q != IDLE && cancel) begin
      state_d     = IDLE;
      heater_d    = '0;
      remaining_d = '0;
      buzzer_d    = 1'b0;
      busy_d      = 1'b0;
      buzz_d      = '0;
      tick_clr    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            if (temp != TEMP_OFF && temp_time != TIME_NONE && !door_open) begin
              state_d     = PREHEAT;
              temp_d      = temp;
              time_d      = temp_time;
              heater_d    = temp;
              busy_d      = 1'b1;
              remaining_d = SEC_W'(temp) * SEC_W'(PREHEAT_PER_LEVEL);
              tick_clr    = 1'b1;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        PREHEAT, COOK: begin
          if (door_open) begin
            state_d  = PAUSE;
            ret_d    = state_q;
            heater_d = '0;
          end else begin
            tick_en = 1'b1;
            if (tick) begin
              if (remaining == ONE_SEC) begin
                if (state_q == PREHEAT) begin
                  state_d     = COOK;
                  remaining_d = SEC_W'(cook_secs(time_q, TIME1, TIME2, TIME3));
                end else begin
                  state_d     = DONE;
                  remaining_d = '0;
                  heater_d    = '0;
                  done_d      = 1'b1;
                  buzzer_d    = 1'b1;
                  buzz_d      = BUZZ_W'(BUZZ_SECS);
                end
              end else begin
                remaining_d = remaining - ONE_SEC;
              end
            end
          end
        end
        PAUSE: begin
          if (!door_open) begin
            state_d  = ret_q;
            heater_d = temp_q;
          end
        end
        DONE: begin
          tick_en = 1'b1;
          if (tick) begin
            if (buzz_q <= BUZZ_W'(1)) begin
              state_d  = IDLE;
              buzz_d   = '0;
              buzzer_d = 1'b0;
              busy_d   = 1'b0;
            end else begin
              buzz_d = buzz_q - BUZZ_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
